bus_xfer_ctrl: RTL and testbench

Sequencer for register-to-register moves over the shared tri-state data bus. It accepts one transfer request at a time with a valid/ready handshake. For each request it drives the `oenable` of exactly one source register, lets the bus settle, then asserts `wenable` of exactly one destination register so the destination captures the bus value. It is the consumer/controller side of the bus that the tri-state bus registers drive, and it guarantees no two drivers are ever enabled together.

---
 rtl/bus_xfer_ctrl.sv | 119 +++++++++++
 tb/tb_bus_xfer_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: drives one source oenable, lets the bus settle, then pulses one destination wenable.
// Optional feature macro XFER_SNOOP_EN adds snoop_data, which captures the bus value on each completed write.
module bus_xfer_ctrl #(
    parameter int NREGS         = 8,
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1,
    localparam int SELW         = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SELW-1:0]  req_src,
    input  logic [SELW-1:0]  req_dst,
    input  logic [WIDTH-1:0] bus_in,
    output logic [NREGS-1:0] oenable,
    output logic [NREGS-1:0] wenable,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef XFER_SNOOP_EN
    ,
    output logic [WIDTH-1:0] snoop_data
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, WRITE, REJECT} state_t;

    state_t           state, state_nxt;
    logic [SELW-1:0]  src_q, dst_q, src_nxt, dst_nxt;
    logic [3:0]       cnt_q, cnt_nxt;
    logic             legal;
    logic [NREGS-1:0] oen_nxt, wen_nxt;
    logic             ready_nxt, busy_nxt, done_nxt, err_nxt;

    assign legal = (int'(req_src) < NREGS) && (int'(req_dst) < NREGS) && (req_src != req_dst);

    // Outputs are decoded from the next state so the registered enables line up with the state they belong to.
    always_comb begin
        state_nxt = state;
        src_nxt   = src_q;
        dst_nxt   = dst_q;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    src_nxt = req_src;
                    dst_nxt = req_dst;
                    if (legal) begin
                        state_nxt = DRIVE;
                        cnt_nxt   = 4'(SETTLE_CYCLES - 1);
                    end else begin
                        state_nxt = REJECT;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q != 4'd0) cnt_nxt = cnt_q - 4'd1;
                else               state_nxt = WRITE;
            end
            WRITE:   state_nxt = IDLE;
            REJECT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        oen_nxt = '0;
        wen_nxt = '0;
        if (state_nxt == DRIVE || state_nxt == WRITE) oen_nxt = NREGS'(1) << src_nxt;
        if (state_nxt == WRITE)                       wen_nxt = NREGS'(1) << dst_nxt;
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state == WRITE);
        err_nxt   = (state == REJECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            src_q <= src_nxt;
            dst_q <= dst_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Reset drops every enable at once so an aborted transfer can never leave two drivers on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oenable   <= '0;
            wenable   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            oenable   <= oen_nxt;
            wenable   <= wen_nxt;
            req_ready <= ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

`ifdef XFER_SNOOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              snoop_data <= '0;
        else if (state == WRITE) snoop_data <= bus_in;
    end
`else
    logic unused_bus;
    assign unused_bus = ^bus_in;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: two instances (8 regs/settle 3 and 6 regs/settle 1) share a modelled register file.
// Expected behaviour comes from a transaction-level timeline model and an array mirror of the register contents.
module tb_bus_xfer_ctrl;

    localparam int WIDTH = 8;
    localparam int NA = 8, SA = 3;
    localparam int NB = 6, SB = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             reqValidA, reqValidB;
    logic [2:0]       reqSrc, reqDst;
    logic [WIDTH-1:0] busIn;

    logic          readyA, busyA, doneA, errA;
    logic [NA-1:0] oenA, wenA;
    logic          readyB, busyB, doneB, errB;
    logic [NB-1:0] oenB, wenB;
`ifdef XFER_SNOOP_EN
    logic [WIDTH-1:0] snoopA, snoopB;
`endif

    bus_xfer_ctrl #(.NREGS(NA), .WIDTH(WIDTH), .SETTLE_CYCLES(SA)) dutA (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValidA), .req_ready(readyA),
        .req_src(reqSrc), .req_dst(reqDst), .bus_in(busIn),
        .oenable(oenA), .wenable(wenA), .busy(busyA), .done(doneA), .err(errA)
`ifdef XFER_SNOOP_EN
        , .snoop_data(snoopA)
`endif
    );

    bus_xfer_ctrl #(.NREGS(NB), .WIDTH(WIDTH), .SETTLE_CYCLES(SB)) dutB (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValidB), .req_ready(readyB),
        .req_src(reqSrc), .req_dst(reqDst), .bus_in(busIn),
        .oenable(oenB), .wenable(wenB), .busy(busyB), .done(doneB), .err(errB)
`ifdef XFER_SNOOP_EN
        , .snoop_data(snoopB)
`endif
    );

    int compared = 0;
    int mismatched = 0;
    int sel = 0;
    logic invOn = 1'b0;

    logic [7:0] oen, wen;
    logic       ready, busy, done, err;
    logic [WIDTH-1:0] snoop, snoopExpA, snoopExpB;

    // Observe whichever instance is currently being exercised.
    always_comb begin
        if (sel == 0) begin
            oen = oenA; wen = wenA; ready = readyA; busy = busyA; done = doneA; err = errA;
        end else begin
            oen = {2'b00, oenB}; wen = {2'b00, wenB}; ready = readyB; busy = busyB; done = doneB; err = errB;
        end
`ifdef XFER_SNOOP_EN
        snoop = (sel == 0) ? snoopA : snoopB;
`else
        snoop = '0;
`endif
    end

    // Tri-state register file: enabled registers OR onto the bus, so a double drive corrupts the value.
    logic [WIDTH-1:0] regs [8];
    logic [WIDTH-1:0] loadVal [8];
    logic [WIDTH-1:0] mem [8];
    logic loadRegs = 1'b0;

    always_comb begin
        busIn = '0;
        for (int i = 0; i < 8; i++) if (oen[i]) busIn = busIn | regs[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (loadRegs)    regs[i] <= loadVal[i];
            else if (wen[i]) regs[i] <= busIn;
        end
    end

    logic pendingDone, pendingErr;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%h expected=%h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Structural invariants on both instances every cycle.
    always @(negedge clk) begin
        if (invOn) begin
            checkOutput("onehotOenA", 32'($onehot0(oenA)), 32'd1);
            checkOutput("onehotWenA", 32'($onehot0(wenA)), 32'd1);
            checkOutput("wenNeedsOenA", 32'((wenA == '0) || ((oenA != '0))), 32'd1);
            checkOutput("onehotOenB", 32'($onehot0(oenB)), 32'd1);
            checkOutput("onehotWenB", 32'($onehot0(wenB)), 32'd1);
            checkOutput("wenNeedsOenB", 32'((wenB == '0) || ((oenB != '0))), 32'd1);
        end
    end

    task automatic setValid(input logic v);
        reqValidA = (sel == 0) ? v : 1'b0;
        reqValidB = (sel == 1) ? v : 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_oen"}, 32'(oen), 32'd0);
        checkOutput({tag, "_wen"}, 32'(wen), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'(pendingDone));
        checkOutput({tag, "_err"}, 32'(err), 32'(pendingErr));
        pendingDone = 1'b0;
        pendingErr  = 1'b0;
    endtask

    task automatic idleCycle();
        setValid(1'b0);
        checkIdle("idle");
        @(negedge clk);
    endtask

    // One request on the selected instance, called on the negedge of an idle cycle.
    task automatic applyStimulus(input logic [2:0] src, input logic [2:0] dst, input logic hold);
        int n, settle;
        logic legal;
        logic [WIDTH-1:0] busVal;
        n      = (sel == 0) ? NA : NB;
        settle = (sel == 0) ? SA : SB;
        legal  = (int'(src) < n) && (int'(dst) < n) && (src != dst);
        checkIdle("accept");
        reqSrc = src;
        reqDst = dst;
        setValid(1'b1);
        @(negedge clk);
        if (!hold) begin
            setValid(1'b0);
            reqSrc = 3'($urandom);
            reqDst = 3'($urandom);
        end
        if (legal) begin
            busVal = mem[src];
            for (int k = 1; k <= settle + 1; k++) begin
                checkOutput("xferOen", 32'(oen), 32'(1) << src);
                checkOutput("xferWen", 32'(wen), (k == settle + 1) ? (32'(1) << dst) : 32'd0);
                checkOutput("xferBusy", 32'(busy), 32'd1);
                checkOutput("xferReady", 32'(ready), 32'd0);
                checkOutput("xferDoneEarly", 32'(done), 32'd0);
                checkOutput("xferErr", 32'(err), 32'd0);
                @(negedge clk);
            end
            mem[dst] = busVal;
            if (sel == 0) snoopExpA = busVal; else snoopExpB = busVal;
            pendingDone = 1'b1;
            checkOutput("dstValue", 32'(regs[dst]), 32'(mem[dst]));
        end else begin
            checkOutput("rejOen", 32'(oen), 32'd0);
            checkOutput("rejWen", 32'(wen), 32'd0);
            checkOutput("rejBusy", 32'(busy), 32'd1);
            checkOutput("rejReady", 32'(ready), 32'd0);
            checkOutput("rejErrEarly", 32'(err), 32'd0);
            @(negedge clk);
            pendingErr = 1'b1;
        end
`ifdef XFER_SNOOP_EN
        checkOutput("snoop", 32'(snoop), 32'((sel == 0) ? snoopExpA : snoopExpB));
`endif
    endtask

    // Reset asserted in the WRITE cycle of a transfer on instance A.
    task automatic resetMidWrite();
        sel = 0;
        checkIdle("rstAccept");
        reqSrc = 3'd1;
        reqDst = 3'd6;
        setValid(1'b1);
        @(negedge clk);
        setValid(1'b0);
        for (int k = 1; k <= SA + 1; k++) begin
            checkOutput("rstPreOen", 32'(oen), 32'h02);
            if (k <= SA) @(negedge clk);
        end
        checkOutput("rstPreWen", 32'(wen), 32'h40);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstOen", 32'(oen), 32'd0);
        checkOutput("rstWen", 32'(wen), 32'd0);
        checkOutput("rstReady", 32'(ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pendingDone = 1'b0;
        pendingErr  = 1'b0;
        for (int k = 0; k < 3; k++) idleCycle();
        checkOutput("rstDstKept", 32'(regs[6]), 32'(mem[6]));
`ifdef XFER_SNOOP_EN
        snoopExpA = '0;
        snoopExpB = '0;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int newSel, gap;
        logic hold;
        rst_n = 1'b0;
        reqValidA = 1'b0;
        reqValidB = 1'b0;
        reqSrc = '0;
        reqDst = '0;
        pendingDone = 1'b0;
        pendingErr  = 1'b0;
        snoopExpA = '0;
        snoopExpB = '0;
        for (int i = 0; i < 8; i++) begin
            loadVal[i] = 8'($urandom);
            mem[i] = loadVal[i];
        end
        loadVal[2] = 8'hA5;
        mem[2] = 8'hA5;
        loadRegs = 1'b1;
        @(negedge clk);
        @(negedge clk);
        loadRegs = 1'b0;
        sel = 0;
        checkIdle("resetA");
        sel = 1;
        checkIdle("resetB");
`ifdef XFER_SNOOP_EN
        checkOutput("resetSnoop", 32'(snoop), 32'd0);
`endif
        rst_n = 1'b1;
        invOn = 1'b1;
        @(negedge clk);

        // Instance B (settle 1, six registers): basic move, then rejects.
        sel = 1;
        applyStimulus(3'd2, 3'd5, 1'b0);
        idleCycle();
        checkOutput("dstA5", 32'(regs[5]), 32'hA5);
        applyStimulus(3'd3, 3'd3, 1'b0);
        idleCycle();
        applyStimulus(3'd7, 3'd1, 1'b0);
        idleCycle();
        applyStimulus(3'd1, 3'd6, 1'b0);
        idleCycle();

        // Instance A (settle 3, eight registers): long move, reject, back-to-back with valid held.
        sel = 0;
        applyStimulus(3'd0, 3'd7, 1'b0);
        idleCycle();
        applyStimulus(3'd3, 3'd3, 1'b0);
        idleCycle();
        applyStimulus(3'd1, 3'd2, 1'b1);
        applyStimulus(3'd2, 3'd1, 1'b0);
        idleCycle();

        resetMidWrite();

        for (int t = 0; t < 1500; t++) begin
            newSel = int'($urandom_range(0, 1));
            if (newSel != sel) begin
                idleCycle();
                sel = newSel;
            end
            hold = 1'($urandom_range(0, 1));
            applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), hold);
            gap = hold ? 0 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idleCycle();
        end
        idleCycle();
        idleCycle();
        invOn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
